// File: rtl/alarm_pkg.sv
// Shared types and time-field widths for the alarm scheduler.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RING = 2'd1,
      ST_COOL = 2'd2
   } state_t;

   localparam int HOUR_W      = 5;
   localparam int MIN_W       = 6;
   localparam int SEC_W       = 6;
   localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/alarm_scheduler_if.sv
// Bus between the alarm scheduler and its neighbours: time-keeping counter,
// user-config logic, user buttons and the light blinker.
interface alarm_scheduler_if #(
   parameter int NUM_SLOTS = 4
);
   import alarm_pkg::*;

   localparam int SW = $clog2(NUM_SLOTS);

   logic              tick_1hz;
   logic [HOUR_W-1:0] cur_hour;
   logic [MIN_W-1:0]  cur_min;
   logic [SEC_W-1:0]  cur_sec;

   logic              cfg_we;
   logic [SW-1:0]     cfg_slot;
   logic [HOUR_W-1:0] cfg_hour;
   logic [MIN_W-1:0]  cfg_min;
   logic              cfg_en;

   logic              dismiss;
   logic              snooze;

   logic              reach_alarm;
   logic              ringing;
   logic [SW-1:0]     active_slot;
   logic [NUM_SLOTS-1:0] pending;

   modport master (
      output tick_1hz, cur_hour, cur_min, cur_sec,
      output cfg_we, cfg_slot, cfg_hour, cfg_min, cfg_en,
      output dismiss, snooze,
      input  reach_alarm, ringing, active_slot, pending
   );

   modport slave (
      input  tick_1hz, cur_hour, cur_min, cur_sec,
      input  cfg_we, cfg_slot, cfg_hour, cfg_min, cfg_en,
      input  dismiss, snooze,
      output reach_alarm, ringing, active_slot, pending
   );

endinterface

// File: rtl/alarm_slot_match.sv
// One alarm slot: stored hour/minute/enable plus the per-second comparator.
// The comparator uses the stored value, so a write during a match tick
// only affects the following ticks.
module alarm_slot_match
   import alarm_pkg::*;
(
   input  logic              clk_sys,
   input  logic              rstn,
   input  logic              we,
   input  logic [HOUR_W-1:0] cfg_hour,
   input  logic [MIN_W-1:0]  cfg_min,
   input  logic              cfg_en,
   input  logic              tick_1hz,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [SEC_W-1:0]  cur_sec,
   output logic              match
);

   logic [HOUR_W-1:0] hour_q, hour_d;
   logic [MIN_W-1:0]  min_q, min_d;
   logic              en_q, en_d;

   // Slot contents: take the new value on a write, otherwise hold.
   always_comb begin
      hour_d = hour_q;
      min_d  = min_q;
      en_d   = en_q;
      if (we) begin
         hour_d = cfg_hour;
         min_d  = cfg_min;
         en_d   = cfg_en;
      end
   end

   // Slot register; reset leaves the slot disabled at 00:00.
   always_ff @(posedge clk_sys or negedge rstn) begin
      if (!rstn) begin
         hour_q <= '0;
         min_q  <= '0;
         en_q   <= 1'b0;
      end else begin
         hour_q <= hour_d;
         min_q  <= min_d;
         en_q   <= en_d;
      end
   end

   assign match = tick_1hz && en_q && (hour_q == cur_hour) &&
                  (min_q == cur_min) && (cur_sec == '0);

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm scheduler: slot matching, lowest-index arbitration, blinker guard
// window, dismiss and optional snooze.
// Optional feature macro: ALARM_SNOOZE_EN (snooze timer and re-queue).
//
// state | meaning
// IDLE  | waiting for a pending slot
// RING  | blinker running for active_slot, user may dismiss/snooze
// COOL  | user acted, guard counter still running out the blink sequence
module alarm_scheduler
   import alarm_pkg::*;
#(
   parameter int NUM_SLOTS   = 4,
   parameter int RING_CYCLES = 67108863,
   parameter int SNOOZE_MIN  = 5
) (
   input logic              clk_sys,
   input logic              rstn,
   alarm_scheduler_if.slave bus
);

   localparam int SW = $clog2(NUM_SLOTS);
   localparam int GW = $clog2(RING_CYCLES + 1);
   localparam logic [GW-1:0] RING_LOAD = GW'(RING_CYCLES - 1);

   state_t               state_q, state_d;
   logic [NUM_SLOTS-1:0] pending_q, pending_d;
   logic [SW-1:0]        active_slot_q, active_slot_d;
   logic [GW-1:0]        guard_q, guard_d;
   logic                 reach_alarm_q, reach_alarm_d;

   logic [NUM_SLOTS-1:0] match;
   logic [NUM_SLOTS-1:0] cfg_kill;
   logic [NUM_SLOTS-1:0] active_mask;
   logic [NUM_SLOTS-1:0] snz_set;
   logic                 snz_take;
   logic                 win_valid;
   logic [SW-1:0]        win_slot;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      alarm_slot_match u_slot (
         .clk_sys  (clk_sys),
         .rstn     (rstn),
         .we       (bus.cfg_we && (bus.cfg_slot == SW'(i))),
         .cfg_hour (bus.cfg_hour),
         .cfg_min  (bus.cfg_min),
         .cfg_en   (bus.cfg_en),
         .tick_1hz (bus.tick_1hz),
         .cur_hour (bus.cur_hour),
         .cur_min  (bus.cur_min),
         .cur_sec  (bus.cur_sec),
         .match    (match[i])
      );
   end

   // Slots being disabled this cycle, and lowest-index pending winner.
   always_comb begin
      cfg_kill  = '0;
      win_valid = 1'b0;
      win_slot  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cfg_kill[i] = bus.cfg_we && !bus.cfg_en && (bus.cfg_slot == SW'(i));
      end
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            win_valid = 1'b1;
            win_slot  = SW'(i);
         end
      end
   end

   assign active_mask = (state_q == ST_RING) ? (NUM_SLOTS'(1) << active_slot_q) : '0;

`ifdef ALARM_SNOOZE_EN
   localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MIN * SEC_PER_MIN);

   logic          snz_armed_q, snz_armed_d;
   logic [11:0]   snz_cnt_q, snz_cnt_d;
   logic [SW-1:0] snz_slot_q, snz_slot_d;
   logic          snz_fire;

   assign snz_take = (state_q == ST_RING) && bus.snooze && !bus.dismiss;

   // Snooze timer: counts seconds, fires on the tick that reaches zero.
   always_comb begin
      snz_armed_d = snz_armed_q;
      snz_cnt_d   = snz_cnt_q;
      snz_slot_d  = snz_slot_q;
      snz_fire    = 1'b0;
      if (snz_armed_q && bus.tick_1hz) begin
         if (snz_cnt_q <= 12'd1) begin
            snz_fire    = 1'b1;
            snz_armed_d = 1'b0;
            snz_cnt_d   = '0;
         end else begin
            snz_cnt_d = snz_cnt_q - 12'd1;
         end
      end
      if (snz_armed_q && bus.cfg_we && !bus.cfg_en && (bus.cfg_slot == snz_slot_q)) begin
         snz_fire    = 1'b0;
         snz_armed_d = 1'b0;
         snz_cnt_d   = '0;
      end
      if (snz_take) begin
         snz_armed_d = 1'b1;
         snz_cnt_d   = SNZ_LOAD;
         snz_slot_d  = active_slot_q;
      end
   end

   // Snooze timer registers.
   always_ff @(posedge clk_sys or negedge rstn) begin
      if (!rstn) begin
         snz_armed_q <= 1'b0;
         snz_cnt_q   <= '0;
         snz_slot_q  <= '0;
      end else begin
         snz_armed_q <= snz_armed_d;
         snz_cnt_q   <= snz_cnt_d;
         snz_slot_q  <= snz_slot_d;
      end
   end

   assign snz_set = snz_fire ? (NUM_SLOTS'(1) << snz_slot_q) : '0;
`else
   assign snz_take = 1'b0;
   assign snz_set  = '0;
`endif

   // FSM next state, pending bookkeeping and guard counter.
   always_comb begin
      state_d       = state_q;
      active_slot_d = active_slot_q;
      reach_alarm_d = 1'b0;
      guard_d       = (guard_q != '0) ? guard_q - GW'(1) : '0;
      pending_d     = pending_q | (match & ~active_mask) | snz_set;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d       = ST_RING;
               active_slot_d = win_slot;
               reach_alarm_d = 1'b1;
               guard_d       = RING_LOAD;
            end
         end
         ST_RING: begin
            if (bus.dismiss || snz_take) begin
               pending_d[active_slot_q] = 1'b0;
               state_d = ST_COOL;
            end else if (cfg_kill[active_slot_q]) begin
               state_d = ST_COOL;
            end else if (guard_q == '0) begin
               pending_d[active_slot_q] = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_COOL: begin
            if (guard_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      pending_d = pending_d & ~cfg_kill;
   end

   // Scheduler state registers.
   always_ff @(posedge clk_sys or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         pending_q     <= '0;
         active_slot_q <= '0;
         guard_q       <= '0;
         reach_alarm_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         active_slot_q <= active_slot_d;
         guard_q       <= guard_d;
         reach_alarm_q <= reach_alarm_d;
      end
   end

   assign bus.reach_alarm = reach_alarm_q;
   assign bus.ringing     = (state_q == ST_RING);
   assign bus.active_slot = active_slot_q;
   assign bus.pending     = pending_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with RING_CYCLES=20, SNOOZE_MIN=1.
module tb_alarm_scheduler;
   import alarm_pkg::*;

   localparam int NS = 4;

   logic clk_sys = 1'b0;
   logic rstn    = 1'b1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulse_cnt = 0;
   int pulse_cyc = 0;
   int ring_cnt  = 0;

   alarm_scheduler_if #(.NUM_SLOTS(NS)) bus ();

   alarm_scheduler #(
      .NUM_SLOTS   (NS),
      .RING_CYCLES (20),
      .SNOOZE_MIN  (1)
   ) dut (
      .clk_sys (clk_sys),
      .rstn    (rstn),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      if (bus.reach_alarm === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         pulse_cyc = cyc;
      end
      if (bus.ringing === 1'b1) ring_cnt = ring_cnt + 1;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic do_tick(input int h, input int m, input int s);
      bus.tick_1hz = 1'b1;
      bus.cur_hour = HOUR_W'(h);
      bus.cur_min  = MIN_W'(m);
      bus.cur_sec  = SEC_W'(s);
      step(1);
      bus.tick_1hz = 1'b0;
   endtask

   task automatic cfg_write(input int slot, input int h, input int m, input bit en);
      bus.cfg_we   = 1'b1;
      bus.cfg_slot = 2'(slot);
      bus.cfg_hour = HOUR_W'(h);
      bus.cfg_min  = MIN_W'(m);
      bus.cfg_en   = en;
      step(1);
      bus.cfg_we   = 1'b0;
   endtask

   task automatic wait_pulses(input int target, input int budget, output bit ok);
      int n = 0;
      while (pulse_cnt < target && n < budget) begin
         step(1);
         n++;
      end
      ok = (pulse_cnt >= target);
   endtask

   task automatic test_reset();
      bus.tick_1hz = 1'b0; bus.cur_hour = '0; bus.cur_min = '0; bus.cur_sec = '0;
      bus.cfg_we = 1'b0; bus.cfg_slot = '0; bus.cfg_hour = '0; bus.cfg_min = '0;
      bus.cfg_en = 1'b0; bus.dismiss = 1'b0; bus.snooze = 1'b0;
      #1 rstn = 1'b0;
      step(3);
      rstn = 1'b1;
      step(2);
      total++;
      if (bus.reach_alarm !== 1'b0 || bus.ringing !== 1'b0 ||
          bus.active_slot !== 2'd0 || bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL reset_outputs: got reach=%b ring=%b slot=%0d pend=%b want 0 0 0 0000",
                  bus.reach_alarm, bus.ringing, bus.active_slot, bus.pending);
      end
      do_tick(0, 0, 0);
      step(2);
      total++;
      if (bus.pending !== 4'b0000 || pulse_cnt !== 0) begin
         bad++;
         $display("FAIL reset_slots_disabled: got pend=%b pulses=%0d want 0000 0", bus.pending, pulse_cnt);
      end
   endtask

   task automatic test_basic();
      int p0, r0, t0;
      bit ok;
      cfg_write(0, 7, 30, 1'b1);
      do_tick(7, 30, 5);
      step(1);
      total++;
      if (bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL basic_nonzero_sec: got pend=%b want 0000", bus.pending);
      end
      p0 = pulse_cnt; r0 = ring_cnt; t0 = cyc;
      do_tick(7, 30, 0);
      total++;
      if (bus.pending !== 4'b0001) begin
         bad++;
         $display("FAIL basic_pending_set: got pend=%b want 0001", bus.pending);
      end
      wait_pulses(p0 + 1, 10, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL basic_pulse_timeout: got pulses=%0d want %0d", pulse_cnt - p0, 1);
      end
      total++;
      if (pulse_cyc - t0 !== 2) begin
         bad++;
         $display("FAIL basic_latency: got %0d cycles want 2", pulse_cyc - t0);
      end
      total++;
      if (bus.active_slot !== 2'd0 || bus.ringing !== 1'b1) begin
         bad++;
         $display("FAIL basic_active: got slot=%0d ring=%b want 0 1", bus.active_slot, bus.ringing);
      end
      step(25);
      total++;
      if (ring_cnt - r0 !== 20) begin
         bad++;
         $display("FAIL basic_ring_len: got %0d want 20", ring_cnt - r0);
      end
      total++;
      if (bus.pending !== 4'b0000 || pulse_cnt - p0 !== 1) begin
         bad++;
         $display("FAIL basic_after_timeout: got pend=%b pulses=%0d want 0000 1", bus.pending, pulse_cnt - p0);
      end
   endtask

   task automatic test_priority();
      int p0, c1;
      bit ok;
      cfg_write(1, 8, 0, 1'b1);
      cfg_write(2, 8, 0, 1'b1);
      p0 = pulse_cnt;
      do_tick(8, 0, 0);
      wait_pulses(p0 + 1, 10, ok);
      c1 = pulse_cyc;
      total++;
      if (!ok || bus.active_slot !== 2'd1 || bus.pending !== 4'b0110) begin
         bad++;
         $display("FAIL prio_first: got ok=%b slot=%0d pend=%b want 1 1 0110", ok, bus.active_slot, bus.pending);
      end
      wait_pulses(p0 + 2, 40, ok);
      total++;
      if (!ok || pulse_cyc - c1 !== 21) begin
         bad++;
         $display("FAIL prio_spacing: got ok=%b spacing=%0d want 1 21", ok, pulse_cyc - c1);
      end
      total++;
      if (bus.active_slot !== 2'd2) begin
         bad++;
         $display("FAIL prio_second_slot: got %0d want 2", bus.active_slot);
      end
      step(25);
      total++;
      if (bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL prio_drained: got pend=%b want 0000", bus.pending);
      end
   endtask

   task automatic test_dismiss();
      int p0, c1;
      bit ok;
      cfg_write(1, 9, 0, 1'b1);
      cfg_write(3, 9, 1, 1'b1);
      p0 = pulse_cnt;
      do_tick(9, 0, 0);
      wait_pulses(p0 + 1, 10, ok);
      c1 = pulse_cyc;
      step(1);
      bus.dismiss = 1'b1;
      step(1);
      bus.dismiss = 1'b0;
      total++;
      if (!ok || bus.ringing !== 1'b0 || bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL dismiss_stop: got ok=%b ring=%b pend=%b want 1 0 0000", ok, bus.ringing, bus.pending);
      end
      do_tick(9, 1, 0);
      total++;
      if (bus.pending !== 4'b1000 || pulse_cnt !== p0 + 1) begin
         bad++;
         $display("FAIL dismiss_cool_queue: got pend=%b pulses=%0d want 1000 1", bus.pending, pulse_cnt - p0);
      end
      wait_pulses(p0 + 2, 40, ok);
      total++;
      if (!ok || pulse_cyc - c1 !== 21 || bus.active_slot !== 2'd3) begin
         bad++;
         $display("FAIL dismiss_guard: got ok=%b spacing=%0d slot=%0d want 1 21 3",
                  ok, pulse_cyc - c1, bus.active_slot);
      end
      step(25);
      total++;
      if (bus.pending !== 4'b0000 || bus.ringing !== 1'b0) begin
         bad++;
         $display("FAIL dismiss_missed_clear: got pend=%b ring=%b want 0000 0", bus.pending, bus.ringing);
      end
   endtask

`ifdef ALARM_SNOOZE_EN
   task automatic test_snooze();
      int p0;
      bit ok;
      p0 = pulse_cnt;
      do_tick(7, 30, 0);
      wait_pulses(p0 + 1, 10, ok);
      bus.snooze = 1'b1;
      step(1);
      bus.snooze = 1'b0;
      total++;
      if (!ok || bus.ringing !== 1'b0 || bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL snooze_stop: got ok=%b ring=%b pend=%b want 1 0 0000", ok, bus.ringing, bus.pending);
      end
      step(25);
      for (int i = 0; i < 59; i++) do_tick(7, 31, i + 1);
      total++;
      if (bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL snooze_early: got pend=%b want 0000 after 59 ticks", bus.pending);
      end
      do_tick(7, 32, 1);
      total++;
      if (bus.pending !== 4'b0001) begin
         bad++;
         $display("FAIL snooze_requeue: got pend=%b want 0001 after 60 ticks", bus.pending);
      end
      wait_pulses(p0 + 2, 10, ok);
      total++;
      if (!ok || bus.active_slot !== 2'd0) begin
         bad++;
         $display("FAIL snooze_second_pulse: got ok=%b slot=%0d want 1 0", ok, bus.active_slot);
      end
      bus.dismiss = 1'b1;
      step(1);
      bus.dismiss = 1'b0;
      step(25);
   endtask

   task automatic test_dismiss_wins();
      int p0;
      bit ok;
      p0 = pulse_cnt;
      do_tick(7, 30, 0);
      wait_pulses(p0 + 1, 10, ok);
      bus.dismiss = 1'b1;
      bus.snooze  = 1'b1;
      step(1);
      bus.dismiss = 1'b0;
      bus.snooze  = 1'b0;
      total++;
      if (!ok || bus.ringing !== 1'b0) begin
         bad++;
         $display("FAIL both_stop: got ok=%b ring=%b want 1 0", ok, bus.ringing);
      end
      step(25);
      for (int i = 0; i < 62; i++) do_tick(7, 31, i % 59 + 1);
      step(3);
      total++;
      if (bus.pending !== 4'b0000 || pulse_cnt !== p0 + 1) begin
         bad++;
         $display("FAIL both_no_requeue: got pend=%b pulses=%0d want 0000 1", bus.pending, pulse_cnt - p0);
      end
   endtask
`else
   task automatic test_snooze_ignored();
      int p0;
      bit ok;
      p0 = pulse_cnt;
      do_tick(7, 30, 0);
      wait_pulses(p0 + 1, 10, ok);
      bus.snooze = 1'b1;
      step(1);
      bus.snooze = 1'b0;
      total++;
      if (!ok || bus.ringing !== 1'b1 || bus.pending !== 4'b0001) begin
         bad++;
         $display("FAIL snooze_ignored: got ok=%b ring=%b pend=%b want 1 1 0001", ok, bus.ringing, bus.pending);
      end
      bus.dismiss = 1'b1;
      step(1);
      bus.dismiss = 1'b0;
      total++;
      if (bus.ringing !== 1'b0) begin
         bad++;
         $display("FAIL snooze_ignored_dismiss: got ring=%b want 0", bus.ringing);
      end
      step(25);
   endtask
`endif

   task automatic test_cfg_and_reset();
      int p0, p1;
      bit ok;
      cfg_write(2, 10, 0, 1'b1);
      p0 = pulse_cnt;
      do_tick(10, 0, 0);
      wait_pulses(p0 + 1, 10, ok);
      step(1);
      cfg_write(2, 10, 0, 1'b0);
      total++;
      if (!ok || bus.ringing !== 1'b0 || bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL cfg_disable_active: got ok=%b ring=%b pend=%b want 1 0 0000", ok, bus.ringing, bus.pending);
      end
      step(30);
      total++;
      if (pulse_cnt !== p0 + 1) begin
         bad++;
         $display("FAIL cfg_no_retrigger: got pulses=%0d want 1", pulse_cnt - p0);
      end
      cfg_write(2, 10, 0, 1'b1);
      do_tick(10, 0, 0);
      step(1);
      total++;
      if (bus.reach_alarm !== 1'b1 || bus.active_slot !== 2'd2) begin
         bad++;
         $display("FAIL rst_pre_pulse: got reach=%b slot=%0d want 1 2", bus.reach_alarm, bus.active_slot);
      end
      rstn = 1'b0;
      #1;
      total++;
      if (bus.reach_alarm !== 1'b0 || bus.ringing !== 1'b0 ||
          bus.active_slot !== 2'd0 || bus.pending !== 4'b0000) begin
         bad++;
         $display("FAIL rst_async: got reach=%b ring=%b slot=%0d pend=%b want 0 0 0 0000",
                  bus.reach_alarm, bus.ringing, bus.active_slot, bus.pending);
      end
      step(2);
      rstn = 1'b1;
      step(1);
      p1 = pulse_cnt;
      do_tick(10, 0, 0);
      step(4);
      total++;
      if (bus.pending !== 4'b0000 || pulse_cnt !== p1) begin
         bad++;
         $display("FAIL rst_slots_discarded: got pend=%b pulses=%0d want 0000 0", bus.pending, pulse_cnt - p1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_dismiss();
`ifdef ALARM_SNOOZE_EN
      test_snooze();
      test_dismiss_wins();
`else
      test_snooze_ignored();
`endif
      test_cfg_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
